// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings for the ID/EX stage (ALU ops, ALUOp classes, funct codes, forwarding selects)
package id_ex_stage_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        OP_MEM   = 2'b00,
        OP_BEQ   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_ORI   = 2'b11
    } aluop_e;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // Unknown R-type funct codes fall back to ADD so the ALU never sees an undefined op.
    function automatic logic [3:0] alu_ctrl(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] r_ctl;
        case (funct)
            F_SUB:   r_ctl = ALU_SUB;
            F_AND:   r_ctl = ALU_AND;
            F_OR:    r_ctl = ALU_OR;
            F_SLT:   r_ctl = ALU_SLT;
            F_NOR:   r_ctl = ALU_NOR;
            default: r_ctl = ALU_ADD;
        endcase
        return op == OP_BEQ   ? ALU_SUB :
               op == OP_ORI   ? ALU_OR  :
               op == OP_RTYPE ? r_ctl   : ALU_ADD;
    endfunction
endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: operand forwarding selects for rs/rt from EX/MEM and MEM/WB
//   ex_rs_i, ex_rt_i          source registers of the instruction in EX
//   exmem_we_i, exmem_rd_i    EX/MEM write enable and destination
//   memwb_we_i, memwb_rd_i    MEM/WB write enable and destination
//   fwd_a_o, fwd_b_o          select per operand: 00 reg, 01 MEM/WB, 10 EX/MEM
module forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] ex_rs_i,
    input  logic [RW-1:0] ex_rt_i,
    input  logic          exmem_we_i,
    input  logic [RW-1:0] exmem_rd_i,
    input  logic          memwb_we_i,
    input  logic [RW-1:0] memwb_rd_i,
    output logic [1:0]    fwd_a_o,
    output logic [1:0]    fwd_b_o
);
    // $0 is hard-wired zero, so a write to it is never a valid forwarding source;
    // EX/MEM is checked first because it holds the younger result.
    function automatic logic [1:0] sel(input logic [RW-1:0] r);
        return (exmem_we_i && exmem_rd_i != '0 && exmem_rd_i == r) ? FWD_EXMEM :
               (memwb_we_i && memwb_rd_i != '0 && memwb_rd_i == r) ? FWD_MEMWB : FWD_REG;
    endfunction

    assign fwd_a_o = sel(ex_rs_i);
    assign fwd_b_o = sel(ex_rt_i);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, ALU control decode and load-use hazard detection
//   clk, rst_n                     clock, async active-low reset
//   stall, flush                   hold / bubble requests (flush has priority)
//   id_*                           decoded operands and control from ID
//   exmem_*, memwb_*               forwarding sources
//   ALUsrc1, ALUsrc2, ALUControl   ALU operands and operation
//   ex_store_data, ex_dest, ex_*   values passed on to EX/MEM
//   load_use_stall                 hold fetch/decode while a load result is pending
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int N  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic [N-1:0]  id_rs_val,
    input  logic [N-1:0]  id_rt_val,
    input  logic [N-1:0]  id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_ALUOp,
    input  logic          id_ALUSrc,
    input  logic          id_RegDst,
    input  logic          id_RegWrite,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          id_MemtoReg,
    input  logic          exmem_RegWrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [N-1:0]  exmem_result,
    input  logic          memwb_RegWrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [N-1:0]  memwb_result,
    output logic [N-1:0]  ALUsrc1,
    output logic [N-1:0]  ALUsrc2,
    output logic [3:0]    ALUControl,
    output logic [N-1:0]  ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_RegWrite,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_MemtoReg,
    output logic          load_use_stall
);
    typedef struct packed {
        logic [N-1:0]  rs_val;
        logic [N-1:0]  rt_val;
        logic [N-1:0]  imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [5:0]    funct;
        logic [1:0]    alu_op;
        logic          alu_src;
        logic          reg_dst;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } idex_t;

    idex_t      id_in, ex_d, ex_q;
    logic [1:0] fwd_a, fwd_b;
    logic [N-1:0] opnd_b;

    assign id_in = '{rs_val: id_rs_val, rt_val: id_rt_val, imm: id_imm,
                     rs: id_rs, rt: id_rt, rd: id_rd, funct: id_funct, alu_op: id_ALUOp,
                     alu_src: id_ALUSrc, reg_dst: id_RegDst, reg_write: id_RegWrite,
                     mem_read: id_MemRead, mem_write: id_MemWrite, mem_to_reg: id_MemtoReg};

    assign load_use_stall = ex_q.mem_read && ex_q.rt != '0 && (ex_q.rt == id_rs || ex_q.rt == id_rt);

    // An all-zero record is the bubble: no writes, no memory access, ALUOp 00.
    assign ex_d = flush ? '0 : stall ? ex_q : load_use_stall ? '0 : id_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    forward_unit #(.RW(RW)) u_fwd (
        .ex_rs_i    (ex_q.rs),
        .ex_rt_i    (ex_q.rt),
        .exmem_we_i (exmem_RegWrite),
        .exmem_rd_i (exmem_rd),
        .memwb_we_i (memwb_RegWrite),
        .memwb_rd_i (memwb_rd),
        .fwd_a_o    (fwd_a),
        .fwd_b_o    (fwd_b)
    );

    assign ALUsrc1 = fwd_a == FWD_EXMEM ? exmem_result : fwd_a == FWD_MEMWB ? memwb_result : ex_q.rs_val;
    assign opnd_b  = fwd_b == FWD_EXMEM ? exmem_result : fwd_b == FWD_MEMWB ? memwb_result : ex_q.rt_val;
    assign ALUsrc2       = ex_q.alu_src ? ex_q.imm : opnd_b;
    assign ex_store_data = opnd_b;
    assign ALUControl    = alu_ctrl(ex_q.alu_op, ex_q.funct);
    assign ex_dest       = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
    assign ex_RegWrite   = ex_q.reg_write;
    assign ex_MemRead    = ex_q.mem_read;
    assign ex_MemWrite   = ex_q.mem_write;
    assign ex_MemtoReg   = ex_q.mem_to_reg;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, directly upstream of the ALU.
- Captures decoded operands and control from ID, forwards results from EX/MEM and MEM/WB, and drives ALUsrc1, ALUsrc2 and ALUControl.
- Also contains load-use hazard detection and stall/flush handling for the ID/EX boundary.

Parameters:
- N, 32, datapath width (matches ALU N)
- RW, 5, register-specifier width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold ID/EX contents (downstream back-pressure)
- flush  in  1  load bubble into ID/EX (branch taken / exception)
- id_rs_val, id_rt_val  in  N  register-file read data
- id_imm  in  N  immediate, already sign/zero extended
- id_rs, id_rt, id_rd  in  RW  register specifiers
- id_funct  in  6  instruction funct field
- id_ALUOp  in  2  main-decoder ALU op class
- id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg  in  1  control bits
- exmem_RegWrite  in  1; exmem_rd  in  RW; exmem_result  in  N  EX/MEM forwarding source
- memwb_RegWrite  in  1; memwb_rd  in  RW; memwb_result  in  N  MEM/WB forwarding source
- ALUsrc1, ALUsrc2  out  N  ALU operands (combinational from register + forwarding)
- ALUControl  out  4  ALU operation
- ex_store_data  out  N  forwarded rt value for sw
- ex_dest  out  RW  write register (rd if RegDst else rt)
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg  out  1  registered control passed on to EX/MEM
- load_use_stall  out  1  to PC / IF-ID: hold fetch/decode this cycle

Behaviour:
- Reset (rst_n=0, asynchronous): every register cleared to zero. Outputs: ex_* control 0, ex_dest 0, ALUControl 4'b0010, ALUsrc1/ALUsrc2/ex_store_data 0 unless forwarding inputs are active.
- Register update on rising clk. Priority: flush > stall > load_use_stall > normal load.
  - flush: load bubble.
  - stall: hold all registers.
  - load_use_stall: load bubble.
  - Normal: capture all id_* inputs.
- Bubble: RegWrite/MemRead/MemWrite/MemtoReg/ALUSrc/RegDst=0, ALUOp=00, rs/rt/rd=0, data fields=0.
- Latency: 1 cycle from ID inputs to registered outputs. Forwarding and ALUControl are combinational on registered state.
- Load-use detection: load_use_stall = ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). Combinational; deasserts the cycle after the bubble enters.
- Forward A (operand rs):
  - EX/MEM when exmem_RegWrite & exmem_rd != 0 & exmem_rd == ex_rs.
  - Else MEM/WB when memwb_RegWrite & memwb_rd != 0 & memwb_rd == ex_rs.
  - Else registered rs value. EX/MEM always wins when both match.
- Forward B (operand rt): same rule on ex_rt. Result drives ex_store_data.
- ALUsrc1 = forwarded A. ALUsrc2 = ex_imm if ALUSrc, else forwarded B.
- ALUControl:
  - ALUOp 00 → 0010 (lw/sw/addi).
  - ALUOp 01 → 0110 (beq).
  - ALUOp 11 → 0001 (ori).
  - ALUOp 10 → by funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100, other→0010.
- Register $0 is never a forwarding source.
- stall and load_use_stall together: stall wins (hold); the hazard re-evaluates next cycle.
- flush during stall: bubble loaded.
- Reset mid-instruction: instruction dropped, no retry.

Decomposition:
- Shared package holds:
  - ALUControl encodings (AND, OR, ADD, SUB, SLT, NOR).
  - ALUOp class codes (00, 01, 10, 11).
  - funct constants.
  - Forwarding select encoding: 00 reg, 01 MEM/WB, 10 EX/MEM.
- One natural sub-module: forward_unit. Inputs: ex_rs, ex_rt and the exmem/memwb rd/RegWrite signals. Outputs: two 2-bit selects. Reused by branch comparison later.

Test Plan:
- Reset: rst_n=0 mid-cycle with valid ID inputs → ex_RegWrite=0, ex_dest=0, ALUControl=0010 immediately, without waiting for a clock edge.
- R-type sub with no hazards: id_rs_val=9, id_rt_val=4, ALUOp=10, funct=100010 → next cycle ALUsrc1=9, ALUsrc2=4, ALUControl=0110.
- Double forward: ex_rs=3; exmem_rd=3 with result 0x11; memwb_rd=3 with result 0x22, both RegWrite → ALUsrc1=0x11. Drop exmem_RegWrite → ALUsrc1=0x22.
- $0 guard: ex_rs=0, exmem_rd=0, exmem_RegWrite=1, result 0xFF → ALUsrc1=registered value (0).
- Load-use: lw in EX with ex_rt=5; ID instruction has id_rs=5 → load_use_stall=1. Next cycle EX holds a bubble (all control 0) and load_use_stall=0.
- Stall/flush priority: stall=1 for 2 cycles → outputs unchanged. Then stall=1 and flush=1 together → bubble loaded.
